// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply sequencer.
//   ELEM_W       : width of one vector element / lane (bits)
//   DEF_SIZE     : default number of vector lanes
//   DEF_COLS     : default number of matrix columns per job
//   DEF_VSM_LAT  : default vsm latency (edges from sampling to out)
//   state_t      : sequencer FSM state encoding
package mvm_pkg;

  localparam int ELEM_W      = 8;
  localparam int DEF_SIZE    = 3;
  localparam int DEF_COLS    = 3;
  localparam int DEF_VSM_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/mvm_top.sv
// Matrix-vector multiply wrapper: one mvm_seq driving one vsm.
// The vsm is cleared either by the system reset or by the sequencer.
// Ports:
//   clk, reset          : shared clock and synchronous active-high reset
//   start, busy         : job request / in-progress indication
//   col_addr / col_data : column memory read port
//   x_addr / x_data     : vector memory read port
//   res_data, res_valid, res_ready : result handshake
//   state               : sequencer FSM state
module mvm_top
  import mvm_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int COLS    = DEF_COLS,
  parameter int VSM_LAT = DEF_VSM_LAT,
  localparam int KW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic [KW-1:0]          col_addr,
  input  logic [ELEM_W*SIZE-1:0] col_data,
  output logic [KW-1:0]          x_addr,
  input  logic [ELEM_W-1:0]      x_data,
  output logic [ELEM_W*SIZE-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output state_t                 state
);

  logic                   vsm_reset;
  logic                   vsm_enable;
  logic [ELEM_W*SIZE-1:0] vsm_a;
  logic [ELEM_W-1:0]      vsm_b;
  logic [ELEM_W*SIZE-1:0] vsm_out;
  logic                   vsm_clr;

  assign vsm_clr = reset | vsm_reset;

  mvm_seq #(
    .SIZE    (SIZE),
    .COLS    (COLS),
    .VSM_LAT (VSM_LAT)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .col_addr   (col_addr),
    .col_data   (col_data),
    .x_addr     (x_addr),
    .x_data     (x_data),
    .vsm_reset  (vsm_reset),
    .vsm_enable (vsm_enable),
    .vsm_a      (vsm_a),
    .vsm_b      (vsm_b),
    .vsm_out    (vsm_out),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .state      (state)
  );

  vsm #(
    .SIZE (SIZE)
  ) u_vsm (
    .clk    (clk),
    .reset  (vsm_clr),
    .enable (vsm_enable),
    .a      (vsm_a),
    .b      (vsm_b),
    .out    (vsm_out)
  );

endmodule

// File: rtl/vsm.sv
// Vector-scalar multiply-accumulate unit.
// Each lane accumulates a[lane] * b, wrapping modulo 2^ELEM_W.
// Two-stage pipeline: the edge that samples an enabled input registers
// the lane products; the next edge adds them into the accumulator, so
// out reflects an input two edges after it is sampled.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high clear of products and accumulator
//   enable  : a/b are valid this cycle
//   a       : SIZE packed lanes of ELEM_W bits
//   b       : scalar multiplier
//   out     : SIZE packed accumulator lanes
module vsm
  import mvm_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ELEM_W*SIZE-1:0] a,
  input  logic [ELEM_W-1:0]      b,
  output logic [ELEM_W*SIZE-1:0] out
);

  logic [ELEM_W*SIZE-1:0] prod;
  logic                   prod_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      out        <= '0;
    end else begin
      prod_valid <= enable;
      for (int i = 0; i < SIZE; i++) begin
        prod[i*ELEM_W +: ELEM_W] <= enable ? a[i*ELEM_W +: ELEM_W] * b : '0;
        if (prod_valid) begin
          out[i*ELEM_W +: ELEM_W] <= out[i*ELEM_W +: ELEM_W] + prod[i*ELEM_W +: ELEM_W];
        end
      end
    end
  end

endmodule

// File: rtl/mvm_seq.sv
// Matrix-vector multiply sequencer. Walks COLS matrix columns and the
// matching input-vector elements through an external vsm, waits for the
// vsm pipeline to drain, then presents the accumulated vector as a result.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : job request, only looked at in IDLE
//   busy                : high whenever the FSM is not IDLE
//   col_addr / col_data : column read port (combinational memory)
//   x_addr / x_data     : vector element read port (same index as column)
//   vsm_reset           : registered vsm clear, high for the CLEAR cycle
//   vsm_enable, vsm_a, vsm_b : registered vsm operands
//   vsm_out             : vsm accumulator value
//   res_data, res_valid, res_ready : result output handshake
//   state               : current FSM state, exported for observation
//
// Result handshake: a transfer happens on a rising edge where res_valid
// and res_ready are both high. Once raised, res_valid and res_data stay
// stable until that transfer; res_valid never drops without one (except
// on reset).
module mvm_seq
  import mvm_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int COLS    = DEF_COLS,
  parameter int VSM_LAT = DEF_VSM_LAT,
  localparam int KW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic [KW-1:0]          col_addr,
  input  logic [ELEM_W*SIZE-1:0] col_data,
  output logic [KW-1:0]          x_addr,
  input  logic [ELEM_W-1:0]      x_data,
  output logic                   vsm_reset,
  output logic                   vsm_enable,
  output logic [ELEM_W*SIZE-1:0] vsm_a,
  output logic [ELEM_W-1:0]      vsm_b,
  input  logic [ELEM_W*SIZE-1:0] vsm_out,
  output logic [ELEM_W*SIZE-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output state_t                 state
);

  // DRAIN counts 0..VSM_LAT, i.e. VSM_LAT+1 cycles.
  localparam int DW = $clog2(VSM_LAT + 2);
  localparam logic [KW-1:0] LAST_K     = KW'(COLS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(VSM_LAT);

  state_t        state_q, state_d;
  logic [KW-1:0] k;
  logic [DW-1:0] d_cnt;

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = ISSUE;
      ISSUE:   if (k == LAST_K) state_d = DRAIN;
      DRAIN:   if (d_cnt == DRAIN_LAST) state_d = HOLD;
      // res_valid is always high in HOLD, so res_ready alone completes it.
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign col_addr = (state_q == ISSUE) ? k : '0;
  assign x_addr   = col_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k          <= '0;
      d_cnt      <= '0;
      vsm_reset  <= 1'b1;
      vsm_enable <= 1'b0;
      vsm_a      <= '0;
      vsm_b      <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
    end else begin
      state_q <= state_d;

      // Raised on the edge that enters CLEAR so the vsm sees it for
      // exactly the CLEAR cycle and clears before the first operand.
      vsm_reset <= (state_q == IDLE) && start;

      case (state_q)
        CLEAR: begin
          k     <= '0;
          d_cnt <= '0;
        end
        ISSUE: if (k != LAST_K) k <= k + KW'(1);
        DRAIN: d_cnt <= d_cnt + DW'(1);
        default: ;
      endcase

      if (state_q == ISSUE) begin
        vsm_enable <= 1'b1;
        vsm_a      <= col_data;
        vsm_b      <= x_data;
      end else begin
        vsm_enable <= 1'b0;
        vsm_a      <= '0;
        vsm_b      <= '0;
      end

      if (state_q == DRAIN && d_cnt == DRAIN_LAST) begin
        res_data  <= vsm_out;
        res_valid <= 1'b1;
      end else if (state_q == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvm_seq.sv
module tb_mvm_seq;
  import mvm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        start;
  logic        busy;
  logic [1:0]  col_addr;
  logic [23:0] col_data;
  logic [1:0]  x_addr;
  logic [7:0]  x_data;
  logic        vsm_reset;
  logic        vsm_enable;
  logic [23:0] vsm_a;
  logic [7:0]  vsm_b;
  logic [23:0] vsm_out;
  logic [23:0] res_data;
  logic        res_valid;
  logic        res_ready;
  state_t      state;
  logic        vsm_clr;

  logic [23:0] cols [3];
  logic [7:0]  xs   [3];

  assign col_data = cols[col_addr];
  assign x_data   = xs[x_addr];
  assign vsm_clr  = reset | vsm_reset;

  mvm_seq #(.SIZE(3), .COLS(3), .VSM_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .col_addr   (col_addr),
    .col_data   (col_data),
    .x_addr     (x_addr),
    .x_data     (x_data),
    .vsm_reset  (vsm_reset),
    .vsm_enable (vsm_enable),
    .vsm_a      (vsm_a),
    .vsm_b      (vsm_b),
    .vsm_out    (vsm_out),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .state      (state)
  );

  vsm #(.SIZE(3)) u_vsm (
    .clk    (clk),
    .reset  (vsm_clr),
    .enable (vsm_enable),
    .a      (vsm_a),
    .b      (vsm_b),
    .out    (vsm_out)
  );

  // ---------------- checking ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                      input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    cols[0] = c0; cols[1] = c1; cols[2] = c2;
    xs[0]   = x0; xs[1]   = x1; xs[2]   = x2;
  endtask

  // One job launched from IDLE at the current negedge (cycle 0).
  // stall: cycles res_ready is held low after res_valid rises.
  // poke : pulse start during ISSUE, during HOLD and in the handshake cycle.
  task automatic job(input string tag, input logic [23:0] exp, input int stall, input bit poke);
    res_ready = (stall == 0);
    start = 1'b1;
    tick();                                   // cycle 1: CLEAR
    start = 1'b0;
    check({tag, " clear state"}, 32'(state), 32'(CLEAR));
    check({tag, " clear vsm_reset"}, 32'(vsm_reset), 32'd1);
    check({tag, " clear busy"}, 32'(busy), 32'd1);
    tick();                                   // cycle 2: ISSUE k=0
    check({tag, " issue0 state"}, 32'(state), 32'(ISSUE));
    check({tag, " issue0 col_addr"}, 32'(col_addr), 32'd0);
    check({tag, " issue0 vsm_reset"}, 32'(vsm_reset), 32'd0);
    if (poke) start = 1'b1;
    tick();                                   // cycle 3: ISSUE k=1
    start = 1'b0;
    check({tag, " issue1 col_addr"}, 32'(col_addr), 32'd1);
    check({tag, " issue1 x_addr"}, 32'(x_addr), 32'd1);
    check({tag, " issue1 vsm_enable"}, 32'(vsm_enable), 32'd1);
    check({tag, " issue1 vsm_a"}, 32'(vsm_a), 32'(cols[0]));
    check({tag, " issue1 vsm_b"}, 32'(vsm_b), 32'(xs[0]));
    tick();                                   // cycle 4: ISSUE k=2
    check({tag, " issue2 state"}, 32'(state), 32'(ISSUE));
    check({tag, " issue2 col_addr"}, 32'(col_addr), 32'd2);
    check({tag, " issue2 vsm_a"}, 32'(vsm_a), 32'(cols[1]));
    tick();                                   // cycle 5: DRAIN
    check({tag, " drain state"}, 32'(state), 32'(DRAIN));
    check({tag, " drain col_addr"}, 32'(col_addr), 32'd0);
    check({tag, " drain x_addr"}, 32'(x_addr), 32'd0);
    check({tag, " drain vsm_a"}, 32'(vsm_a), 32'(cols[2]));
    tick();                                   // cycle 6
    check({tag, " drain vsm_enable"}, 32'(vsm_enable), 32'd0);
    check({tag, " drain vsm_a zero"}, 32'(vsm_a), 32'd0);
    check({tag, " drain vsm_b zero"}, 32'(vsm_b), 32'd0);
    tick();                                   // cycle 7
    check({tag, " res_valid early"}, 32'(res_valid), 32'd0);
    tick();                                   // cycle 8: HOLD
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " res_data"}, 32'(res_data), 32'(exp));
    check({tag, " hold state"}, 32'(state), 32'(HOLD));
    for (int s = 0; s < stall; s++) begin
      if (poke) start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " stall res_valid"}, 32'(res_valid), 32'd1);
      check({tag, " stall res_data"}, 32'(res_data), 32'(exp));
    end
    res_ready = 1'b1;
    if (poke) start = 1'b1;                   // start in the handshake cycle
    tick();
    start = 1'b0;
    check({tag, " done state"}, 32'(state), 32'(IDLE));
    check({tag, " done busy"}, 32'(busy), 32'd0);
    check({tag, " done res_valid"}, 32'(res_valid), 32'd0);
    tick();
    check({tag, " no queued start"}, 32'(state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    load(24'h010407, 24'h020508, 24'h030609, 8'h01, 8'h02, 8'h03);
    tick();
    tick();
    check("reset state", 32'(state), 32'(IDLE));
    check("reset busy", 32'(busy), 32'd0);
    check("reset vsm_reset", 32'(vsm_reset), 32'd1);
    check("reset vsm_enable", 32'(vsm_enable), 32'd0);
    check("reset vsm_a", 32'(vsm_a), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", 32'(res_data), 32'd0);
    check("reset col_addr", 32'(col_addr), 32'd0);
    reset = 1'b0;
    tick();
    check("post reset vsm_reset", 32'(vsm_reset), 32'd0);
    check("post reset busy", 32'(busy), 32'd0);

    // Basic job: lanes 1+4+9, 4+10+18, 7+16+27.
    job("basic", 24'h0E2032, 0, 1'b0);

    // Consumer stalls for 5 cycles.
    job("stall", 24'h0E2032, 5, 1'b0);

    // Wrap-around: FF*FF = 01 mod 256, three columns -> 03.
    load(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF);
    job("wrap", 24'h030303, 0, 1'b0);

    // start pokes during ISSUE, HOLD and the handshake cycle are ignored.
    load(24'h010407, 24'h020508, 24'h030609, 8'h01, 8'h02, 8'h03);
    job("poke", 24'h0E2032, 2, 1'b1);

    // Reset mid-ISSUE at k=1 aborts the job.
    start = 1'b1;
    tick();                                   // CLEAR
    start = 1'b0;
    tick();                                   // ISSUE k=0
    tick();                                   // ISSUE k=1
    check("abort k", 32'(col_addr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort state", 32'(state), 32'(IDLE));
    check("abort busy", 32'(busy), 32'd0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("abort no res_valid", 32'(res_valid), 32'd0);
    end
    job("after abort", 24'h0E2032, 0, 1'b0);

    // Back-to-back: second job must not carry the first job's sum.
    job("b2b first", 24'h0E2032, 0, 1'b0);
    load(24'h010203, 24'h040506, 24'h070809, 8'h00, 8'h00, 8'h01);
    job("b2b second", 24'h070809, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mvm_seq.md
MVM_SEQ -- requirements
Module: mvm_seq

Interface
REQ-001 Parameter SIZE, default 3: vector lanes; matches the vsm SIZE.
REQ-002 Parameter COLS, default 3: matrix columns per job.
REQ-003 Parameter VSM_LAT, default 2: clock edges from vsm sampling an enabled input until vsm out reflects it.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 col_addr  output  clog2(COLS)  matrix column index; combinational-read memory.
REQ-009 col_data  input  8*SIZE  column data, valid in the same cycle as col_addr.
REQ-010 x_addr  output  clog2(COLS)  input-vector element index; always equals col_addr.
REQ-011 x_data  input  8  scalar element, valid in the same cycle as x_addr.
REQ-012 vsm_reset, vsm_enable  output  1 each  registered vsm controls.
REQ-013 vsm_a  output  8*SIZE  and  vsm_b  output  8: registered vsm operands.
REQ-014 vsm_out  input  8*SIZE  vsm accumulator.
REQ-015 res_data  output  8*SIZE  captured result; res_valid  output  1; res_ready  input  1.

Function
REQ-016 FSM states: IDLE, CLEAR, ISSUE, DRAIN, HOLD.
REQ-017 IDLE: start=1 -> CLEAR.
REQ-018 CLEAR: lasts 1 cycle; vsm_reset=1 in this cycle only; column counter k cleared to 0; -> ISSUE.
REQ-019 ISSUE: lasts COLS cycles, k=0..COLS-1; col_addr=x_addr=k; on each edge vsm_a<=col_data, vsm_b<=x_data, vsm_enable<=1; after k=COLS-1 -> DRAIN.
REQ-020 DRAIN: lasts VSM_LAT+1 cycles; vsm_enable=0, vsm_a=0, vsm_b=0; on the final DRAIN edge res_data<=vsm_out and res_valid<=1; -> HOLD.
REQ-021 HOLD: res_valid and res_data held stable until res_valid&&res_ready; on that edge res_valid<=0; -> IDLE.
REQ-022 Outside ISSUE, col_addr=x_addr=0.
REQ-023 Latency: with start sampled at edge 0, res_valid is first high COLS+VSM_LAT+3 cycles later (8 cycles for the defaults).
REQ-024 start while busy is ignored; it is not queued.
REQ-025 start in the HOLD handshake cycle is ignored; start is accepted from IDLE in the next cycle.
REQ-026 Arithmetic is unchanged by this block: lane i = sum of col[k].lane(i)*x[k] mod 2^8, wrap-around with no saturation.
REQ-027 Every job begins with CLEAR, so no accumulation carries between jobs.

Reset
REQ-028 While reset=1: state<=IDLE, k<=0, vsm_enable<=0, vsm_a<=0, vsm_b<=0, res_data<=0, res_valid<=0, vsm_reset<=1.
REQ-029 The first cycle after reset deasserts: vsm_reset=0, busy=0.
REQ-030 Reset in any state, including mid-ISSUE or HOLD, aborts the job; no res_valid follows for it.

Structure
REQ-031 Package mvm_pkg holds the state enum, ELEM_W=8, and the default SIZE/COLS/VSM_LAT constants.
REQ-032 No sub-module inside mvm_seq.
REQ-033 Wrapper mvm_top instantiates mvm_seq and one vsm; clk/reset are shared and vsm_reset is OR'd with reset.

Verification
REQ-034 Columns 010407, 020508, 030609; x = 01, 02, 03; start at cycle 0; res_ready=1 -> res_valid at cycle 8 with res_data=0E2032; busy low at cycle 9.
REQ-035 Same job with res_ready held 0 for 5 cycles after res_valid -> res_data stays 0E2032 and res_valid stays 1 throughout; single transfer when res_ready rises.
REQ-036 All columns FFFFFF, x all FF -> res_data=030303 (wrap-around).
REQ-037 start pulsed during ISSUE and during HOLD -> exactly one result; no extra CLEAR.
REQ-038 reset asserted for 1 cycle mid-ISSUE (k=1) -> IDLE, res_valid never asserts; a fresh job then yields 0E2032.
REQ-039 Two back-to-back jobs (second: x = 00, 00, 01) -> second res_data=070809, with no residue from the first job.
